// File: rtl/definitions.sv
// rtl/definitions.sv - shared decode constants and control-sequencer state type
package definitions;

  // Low three instruction bits that select a PC jump.
  localparam logic [2:0] kRSH = 3'b101;

  localparam logic [2:0] DEF_OP_LOAD  = 3'b011;
  localparam logic [2:0] DEF_OP_STORE = 3'b110;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    LOAD_WAIT,
    FLUSH,
    DONE
  } ctrl_state_t;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational raw instruction decode, no sequencing
module ctrl_decode
  import definitions::*;
#(
  parameter int IW = 9,
  parameter int OPW = 3,
  parameter logic [OPW-1:0] OP_LOAD = OPW'(DEF_OP_LOAD),
  parameter logic [OPW-1:0] OP_STORE = OPW'(DEF_OP_STORE)
) (
  input  logic [IW-1:0] instruction,
  output logic          store,
  output logic          load,
  output logic          regwr,
  output logic          jmp,
  output logic          br,
  output logic          halt
);

  logic [OPW-1:0] op;

  assign op    = instruction[IW-1 -: OPW];
  assign store = (op == OP_STORE);
  assign load  = (op == OP_LOAD);
  assign regwr = (instruction[IW-1 -: 2] != 2'b11);
  assign jmp   = (instruction[2:0] == kRSH);
  assign br    = &instruction[3:0];
  assign halt  = &instruction;

endmodule

// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - sequenced control unit: decode plus load stall, branch flush, halt ack
module ctrl_seq
  import definitions::*;
#(
  parameter int IW = 9,
  parameter int OPW = 3,
  parameter logic [OPW-1:0] OP_LOAD = OPW'(DEF_OP_LOAD),
  parameter logic [OPW-1:0] OP_STORE = OPW'(DEF_OP_STORE),
  parameter int LOAD_LAT = 2,
  parameter int FLUSH_CYC = 1
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic          InstValid,
  input  logic [IW-1:0] Instruction,
  input  logic          BrCond,
  output logic          Jump,
  output logic          BranchEn,
  output logic          RegWrEn,
  output logic          MemWrEn,
  output logic          MemRdEn,
  output logic          LoadInst,
  output logic          StoreInst,
  output logic          Stall,
  output logic          Flush,
  output logic          Ack
);

  localparam logic [3:0] LOAD_INIT  = 4'(LOAD_LAT - 1);
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYC - 1);

  ctrl_state_t state;
  logic [3:0]  cnt;
  logic        ack_q;

  logic store, load, regwr, jmp, br, halt;
  logic q, redirect;

  ctrl_decode #(
    .IW(IW),
    .OPW(OPW),
    .OP_LOAD(OP_LOAD),
    .OP_STORE(OP_STORE)
  ) u_decode (
    .instruction(Instruction),
    .store(store),
    .load(load),
    .regwr(regwr),
    .jmp(jmp),
    .br(br),
    .halt(halt)
  );

  assign q        = (state == RUN) & InstValid;
  assign redirect = jmp | (br & BrCond);
  assign Ack      = ack_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      ack_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Start) state <= RUN;
        RUN: begin
          if (InstValid) begin
            if (halt) begin
              state <= DONE;
              ack_q <= 1'b1;
            end else if (load) begin
              cnt   <= LOAD_INIT;
              state <= LOAD_WAIT;
            end else if (redirect) begin
              cnt   <= FLUSH_INIT;
              state <= FLUSH;
            end
          end
        end
        LOAD_WAIT, FLUSH: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else state <= RUN;
        end
        DONE: begin
          if (Start) begin
            state <= RUN;
            ack_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Enables are same-cycle from the instruction; only Ack is carried in a flop.
  always_comb begin
    Jump      = 1'b0;
    BranchEn  = 1'b0;
    RegWrEn   = 1'b0;
    MemWrEn   = 1'b0;
    MemRdEn   = 1'b0;
    LoadInst  = 1'b0;
    StoreInst = 1'b0;
    Stall     = 1'b0;
    Flush     = 1'b0;
    case (state)
      IDLE: Stall = 1'b1;
      RUN: begin
        if (q && !halt) begin
          if (load) begin
            MemRdEn = 1'b1;
            Stall   = 1'b1;
          end else begin
            Jump      = jmp;
            BranchEn  = br & BrCond;
            RegWrEn   = regwr & ~store;
            MemWrEn   = store;
            StoreInst = store;
          end
        end
      end
      LOAD_WAIT: begin
        if (cnt != 4'd0) begin
          Stall = 1'b1;
        end else begin
          RegWrEn  = 1'b1;
          LoadInst = 1'b1;
        end
      end
      FLUSH: Flush = 1'b1;
      DONE:  Stall = 1'b1;
      default: Stall = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// tb/tb_ctrl_seq.sv - scoreboard bench for ctrl_seq with directed vectors
module tb_ctrl_seq;

  logic       Clk = 1'b0;
  logic       Reset_n, Start, InstValid, BrCond;
  logic [8:0] Instruction;
  logic Jump, BranchEn, RegWrEn, MemWrEn, MemRdEn, LoadInst, StoreInst, Stall, Flush, Ack;

  always #5 Clk = ~Clk;

  ctrl_seq #(
    .IW(9), .OPW(3), .OP_LOAD(3'b011), .OP_STORE(3'b110), .LOAD_LAT(2), .FLUSH_CYC(1)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .InstValid(InstValid),
    .Instruction(Instruction), .BrCond(BrCond), .Jump(Jump), .BranchEn(BranchEn),
    .RegWrEn(RegWrEn), .MemWrEn(MemWrEn), .MemRdEn(MemRdEn), .LoadInst(LoadInst),
    .StoreInst(StoreInst), .Stall(Stall), .Flush(Flush), .Ack(Ack)
  );

  // Output vector order: {Jump,BranchEn,RegWrEn,MemWrEn,MemRdEn,LoadInst,StoreInst,Stall,Flush,Ack}
  localparam logic [9:0] J  = 10'b1000000000;
  localparam logic [9:0] B  = 10'b0100000000;
  localparam logic [9:0] RW = 10'b0010000000;
  localparam logic [9:0] MW = 10'b0001000000;
  localparam logic [9:0] MR = 10'b0000100000;
  localparam logic [9:0] LD = 10'b0000010000;
  localparam logic [9:0] ST = 10'b0000001000;
  localparam logic [9:0] SL = 10'b0000000100;
  localparam logic [9:0] FL = 10'b0000000010;
  localparam logic [9:0] AK = 10'b0000000001;

  localparam logic [8:0] I_ADD   = 9'b000000000;
  localparam logic [8:0] I_LOAD  = 9'b011000000;
  localparam logic [8:0] I_STORE = 9'b110000000;
  localparam logic [8:0] I_BR    = 9'b000001111;
  localparam logic [8:0] I_JMP   = 9'b000000101;
  localparam logic [8:0] I_HALT  = 9'b111111111;

  typedef struct {
    logic [9:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  event chk_ev;

  logic [9:0] outs;
  assign outs = {Jump, BranchEn, RegWrEn, MemWrEn, MemRdEn, LoadInst, StoreInst, Stall, Flush, Ack};

  task automatic step(input logic st, input logic vld, input logic brc,
                      input logic [8:0] ins, input logic [9:0] exp, input string name);
    exp_t e;
    @(posedge Clk);
    #1;
    Start       = st;
    InstValid   = vld;
    BrCond      = brc;
    Instruction = ins;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk or chk_ev);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (outs !== e.exp) begin
          n_fail++;
          $display("FAIL %s: outputs got %b expected %b", e.name, outs, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    exp_t e;
    Reset_n = 1'b0; Start = 1'b0; InstValid = 1'b0; BrCond = 1'b0; Instruction = '0;
    step(0, 0, 0, I_ADD, SL, "reset_state");
    Reset_n = 1'b1;
    step(1, 0, 0, I_ADD, SL, "idle_start");
    step(0, 1, 0, I_ADD, RW, "add");
    step(0, 0, 0, I_ADD, '0, "no_valid");
    step(0, 1, 0, I_LOAD, MR | SL, "load_c0");
    step(0, 1, 0, I_LOAD, SL, "load_c1");
    step(0, 1, 0, I_LOAD, RW | LD, "load_c2");
    step(0, 1, 0, I_STORE, MW | ST, "store");
    step(0, 1, 1, I_BR, B | RW, "br_taken");
    step(0, 0, 0, I_ADD, FL, "br_flush");
    step(0, 1, 0, I_BR, RW, "br_not_taken");
    step(0, 1, 0, I_JMP, J | RW, "jump");
    step(0, 0, 0, I_ADD, FL, "jump_flush");
    step(1, 1, 0, I_ADD, RW, "start_ignored_run");
    step(0, 1, 0, I_HALT, '0, "halt");
    step(0, 0, 0, I_ADD, SL | AK, "done_ack");
    step(0, 1, 0, I_ADD, SL | AK, "done_sticky");
    step(1, 0, 0, I_ADD, SL | AK, "done_start");
    step(0, 0, 0, I_ADD, '0, "ack_cleared");
    step(0, 1, 0, I_LOAD, MR | SL, "load2_c0");
    step(0, 1, 0, I_LOAD, SL, "load2_c1");
    // Pull reset after the cycle-1 check so the asynchronous effect is seen in isolation.
    @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    e.exp  = SL;
    e.name = "reset_mid_load";
    sb.push_back(e);
    -> chk_ev;
    step(0, 1, 0, I_LOAD, SL, "reset_hold");
    Reset_n = 1'b1;
    step(0, 0, 0, I_ADD, SL, "post_reset_idle");
    step(1, 0, 0, I_ADD, SL, "post_reset_start");
    step(0, 0, 0, I_ADD, '0, "post_reset_run");
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge Clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
